// File: rtl/multi_buffer_ctrl_if.sv
// rtl/multi_buffer_ctrl_if.sv - producer/consumer word streams of multi_buffer_ctrl
// master = source/sink side, slave = controller side.
interface multi_buffer_ctrl_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  modport master (
    output wr_valid, wr_data, wr_last, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/multi_buffer_ctrl.sv
// rtl/multi_buffer_ctrl.sv - round-robin frame banking over a 2-cycle-read RAM
// Optional statistics ports/counters under MBUF_CTRL_STATS_EN.
module multi_buffer_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int BUFF_NUM   = 4,
  localparam int IW        = $clog2(BUFF_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  multi_buffer_ctrl_if.slave       bus,
  output logic [IW:0]              full_cnt,
  output logic                     wr_trunc,
  output logic                     ram_write_en,
  output logic [ADDR_WIDTH+IW-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  output logic                     ram_read_en,
  output logic [ADDR_WIDTH+IW-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0]    ram_q
`ifdef MBUF_CTRL_STATS_EN
  ,
  output logic [31:0]              frames_in,
  output logic [31:0]              frames_out,
  output logic [15:0]              trunc_cnt
`endif
);
  localparam int LW = ADDR_WIDTH + 1;

  if (BUFF_NUM < 2 || (BUFF_NUM & (BUFF_NUM - 1)) != 0) begin : g_bad_buff_num
    $error("BUFF_NUM must be a power of two >= 2");
  end

  typedef enum logic [1:0] {R_IDLE, R_STREAM, R_DRAIN} rd_state_e;

  rd_state_e             state_q, state_d;
  logic [IW-1:0]         wb_q, wb_d, rb_q, rb_d;
  logic [ADDR_WIDTH-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic [IW:0]           full_cnt_q, full_cnt_d;
  logic [LW-1:0]         len_q [BUFF_NUM];
  logic [LW-1:0]         len_d [BUFF_NUM];
  logic [1:0]            pipe_vld_q, pipe_vld_d, pipe_last_q, pipe_last_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [4];
  logic [DATA_WIDTH-1:0] fifo_data_d [4];
  logic [3:0]            fifo_last_q, fifo_last_d;
  logic [1:0]            fifo_wptr_q, fifo_wptr_d, fifo_rptr_q, fifo_rptr_d;
  logic [2:0]            fifo_cnt_q, fifo_cnt_d;

  logic wr_ready_w, wr_fire, wr_at_cap, commit;
  logic rd_valid_w, pop, push, issue, rd_is_last, release_bank;

  assign wr_ready_w   = rst & (full_cnt_q != (IW+1)'(BUFF_NUM));
  assign wr_fire      = bus.wr_valid & wr_ready_w;
  assign wr_at_cap    = (wr_off_q == {ADDR_WIDTH{1'b1}});
  assign commit       = wr_fire & (bus.wr_last | wr_at_cap);
  assign rd_valid_w   = (fifo_cnt_q != 3'd0);
  assign pop          = rd_valid_w & bus.rd_ready;
  assign push         = pipe_vld_q[1];
  assign rd_is_last   = ({1'b0, rd_off_q} == len_q[rb_q] - LW'(1));
  // Queue slots already claimed by in-flight reads count as occupied.
  assign issue        = (state_q == R_STREAM) &&
                        (({1'b0, fifo_cnt_q} + 4'(pipe_vld_q[0]) + 4'(pipe_vld_q[1])) < 4'd4);
  assign release_bank = (state_q == R_DRAIN) & pop & fifo_last_q[fifo_rptr_q];

  assign bus.wr_ready   = wr_ready_w;
  assign bus.rd_valid   = rd_valid_w;
  assign bus.rd_data    = rd_valid_w ? fifo_data_q[fifo_rptr_q] : '0;
  assign bus.rd_last    = rd_valid_w & fifo_last_q[fifo_rptr_q];
  assign full_cnt       = full_cnt_q;
  assign wr_trunc       = wr_fire & wr_at_cap & ~bus.wr_last;
  assign ram_write_en   = wr_fire;
  assign ram_write_addr = {wb_q, wr_off_q};
  assign ram_data_in    = bus.wr_data;
  assign ram_read_en    = issue;
  assign ram_read_addr  = {rb_q, rd_off_q};

  always_comb begin
    wb_d        = wb_q;
    wr_off_d    = wr_off_q;
    len_d       = len_q;
    full_cnt_d  = full_cnt_q;
    state_d     = state_q;
    rb_d        = rb_q;
    rd_off_d    = rd_off_q;
    pipe_vld_d  = {pipe_vld_q[0], issue};
    pipe_last_d = {pipe_last_q[0], issue & rd_is_last};
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    fifo_wptr_d = fifo_wptr_q;
    fifo_rptr_d = fifo_rptr_q;
    fifo_cnt_d  = fifo_cnt_q;

    if (commit) begin
      len_d[wb_q] = {1'b0, wr_off_q} + LW'(1);
      wb_d        = wb_q + IW'(1);
      wr_off_d    = '0;
    end else if (wr_fire) begin
      wr_off_d = wr_off_q + ADDR_WIDTH'(1);
    end

    case ({commit, release_bank})
      2'b10:   full_cnt_d = full_cnt_q + (IW+1)'(1);
      2'b01:   full_cnt_d = full_cnt_q - (IW+1)'(1);
      default: full_cnt_d = full_cnt_q;
    endcase

    case (state_q)
      R_IDLE: if (full_cnt_q != '0) state_d = R_STREAM;
      R_STREAM: begin
        if (issue) begin
          rd_off_d = rd_off_q + ADDR_WIDTH'(1);
          if (rd_is_last) begin
            rd_off_d = '0;
            state_d  = R_DRAIN;
          end
        end
      end
      R_DRAIN: begin
        if (release_bank) begin
          rb_d    = rb_q + IW'(1);
          state_d = (full_cnt_d != '0) ? R_STREAM : R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase

    if (push) begin
      fifo_data_d[fifo_wptr_q] = ram_q;
      fifo_last_d[fifo_wptr_q] = pipe_last_q[1];
      fifo_wptr_d              = fifo_wptr_q + 2'd1;
    end
    if (pop) fifo_rptr_d = fifo_rptr_q + 2'd1;
    fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= R_IDLE;
      wb_q        <= '0;
      rb_q        <= '0;
      wr_off_q    <= '0;
      rd_off_q    <= '0;
      full_cnt_q  <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      fifo_last_q <= '0;
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
      for (int i = 0; i < BUFF_NUM; i++) len_q[i] <= '0;
      for (int i = 0; i < 4; i++) fifo_data_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wr_off_q    <= wr_off_d;
      rd_off_q    <= rd_off_d;
      full_cnt_q  <= full_cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      fifo_last_q <= fifo_last_d;
      fifo_wptr_q <= fifo_wptr_d;
      fifo_rptr_q <= fifo_rptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      len_q       <= len_d;
      fifo_data_q <= fifo_data_d;
    end
  end

`ifdef MBUF_CTRL_STATS_EN
  logic [31:0] frames_in_q, frames_in_d, frames_out_q, frames_out_d;
  logic [15:0] trunc_cnt_q, trunc_cnt_d;

  always_comb begin
    frames_in_d  = frames_in_q + 32'(commit);
    frames_out_d = frames_out_q + 32'(pop & fifo_last_q[fifo_rptr_q]);
    trunc_cnt_d  = trunc_cnt_q;
    if (wr_trunc && trunc_cnt_q != 16'hFFFF) trunc_cnt_d = trunc_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frames_in_q  <= '0;
      frames_out_q <= '0;
      trunc_cnt_q  <= '0;
    end else begin
      frames_in_q  <= frames_in_d;
      frames_out_q <= frames_out_d;
      trunc_cnt_q  <= trunc_cnt_d;
    end
  end

  assign frames_in  = frames_in_q;
  assign frames_out = frames_out_q;
  assign trunc_cnt  = trunc_cnt_q;
`endif
endmodule

// File: tb/tb_multi_buffer_ctrl.sv
// tb/tb_multi_buffer_ctrl.sv - directed bench for multi_buffer_ctrl with a 2-cycle-read RAM model
module tb_multi_buffer_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int BN = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_buffer_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  logic [IW:0]         full_cnt;
  logic                wr_trunc, ram_write_en, ram_read_en;
  logic [AW+IW-1:0]    ram_write_addr, ram_read_addr;
  logic [DW-1:0]       ram_data_in;
  logic [DW-1:0]       ram_q;
`ifdef MBUF_CTRL_STATS_EN
  logic [31:0]         frames_in, frames_out;
  logic [15:0]         trunc_cnt;
`endif

  multi_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUFF_NUM(BN)) dut (
    .clk            (clk),
    .rst            (rst_n),
    .bus            (bus),
    .full_cnt       (full_cnt),
    .wr_trunc       (wr_trunc),
    .ram_write_en   (ram_write_en),
    .ram_write_addr (ram_write_addr),
    .ram_data_in    (ram_data_in),
    .ram_read_en    (ram_read_en),
    .ram_read_addr  (ram_read_addr),
    .ram_q          (ram_q)
`ifdef MBUF_CTRL_STATS_EN
    ,
    .frames_in      (frames_in),
    .frames_out     (frames_out),
    .trunc_cnt      (trunc_cnt)
`endif
  );

  logic [DW-1:0]    mem [2**(AW+IW)];
  logic [AW+IW-1:0] rd_addr_r;
  logic             rd_en_r = 1'b0;
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_addr] <= ram_data_in;
    rd_en_r <= ram_read_en;
    if (ram_read_en) rd_addr_r <= ram_read_addr;
    if (rd_en_r) ram_q <= mem[rd_addr_r];
  end

  logic [DW:0] got_q[$];
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid && bus.rd_ready) got_q.push_back({bus.rd_last, bus.rd_data});
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic last,
                           output logic [AW+IW-1:0] waddr, output logic trunc);
    int g = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
    while (!bus.wr_ready && g < 100) begin tick(); g++; end
    if (g == 100) check("wr_ready_timeout", 32'(bus.wr_ready), 32'd1);
    waddr = ram_write_addr;
    trunc = wr_trunc;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    int g = 0;
    while (got_q.size() < n && g < 300) begin tick(); g++; end
    check(tag, 32'(got_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    got_q.delete();
  endtask

  logic [AW+IW-1:0] wa;
  logic             tr;
  logic [DW:0]      exp_q[$];

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    bus.rd_ready = 1'b0;
    tick();
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_full_cnt", 32'(full_cnt), 32'd0);
    check("rst_ram_en", 32'({ram_read_en, ram_write_en, wr_trunc}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("wr_ready_up", 32'(bus.wr_ready), 32'd1);

    // single 3-word frame, consumer always ready
    bus.rd_ready = 1'b1;
    push_word(8'hA1, 1'b0, wa, tr); check("t1_waddr0", 32'(wa), 32'h00);
    push_word(8'hB2, 1'b0, wa, tr); check("t1_waddr1", 32'(wa), 32'h01);
    push_word(8'hC3, 1'b1, wa, tr); check("t1_waddr2", 32'(wa), 32'h02);
    check("t1_full_cnt1", 32'(full_cnt), 32'd1);
    begin
      int n = 0;
      while (!bus.rd_valid && n < 20) begin tick(); n++; end
      check("t1_first_rd_latency", 32'(n), 32'd4);
    end
    wait_out("t1_count", 3);
    check("t1_w0", 32'(got_q[0]), 32'h0A1);
    check("t1_w1", 32'(got_q[1]), 32'h0B2);
    check("t1_w2", 32'(got_q[2]), 32'h1C3);
    tick(); tick();
    check("t1_full_cnt0", 32'(full_cnt), 32'd0);

    // four 2-word frames with the consumer stalled
    got_q.delete();
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t2_wr_ready", 32'(bus.wr_ready), 32'd1);
      push_word(8'(8'h10 + i), i[0], wa, tr);
    end
    check("t2_full_cnt4", 32'(full_cnt), 32'd4);
    check("t2_wr_ready_low", 32'(bus.wr_ready), 32'd0);
    bus.rd_ready = 1'b1;
    begin
      int g = 0;
      while (full_cnt != 3'd3 && g < 20) begin tick(); g++; end
      check("t2_full_cnt3", 32'(full_cnt), 32'd3);
      check("t2_wr_ready_back", 32'(bus.wr_ready), 32'd1);
    end
    wait_out("t2_count", 8);
    for (int i = 0; i < 8; i++) check("t2_word", 32'(got_q[i]), {23'd0, i[0], 8'(8'h10 + i)});

    // 16 words without wr_last force-close the bank
    do_reset();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_word(8'(8'h30 + i), 1'b0, wa, tr);
      check("t3_trunc", 32'(tr), (i == 15) ? 32'd1 : 32'd0);
      if (i == 15) check("t3_waddr15", 32'(wa), 32'h0F);
    end
    check("t3_len16", 32'(dut.len_q[0]), 32'd16);
    push_word(8'h99, 1'b1, wa, tr);
    check("t3_waddr17", 32'(wa), 32'h10);
    wait_out("t3_count", 17);
    for (int i = 0; i < 16; i++) check("t3_word", 32'(got_q[i]), {23'd0, (i == 15), 8'(8'h30 + i)});
    check("t3_w16", 32'(got_q[16]), 32'h199);

    // six frames, consumer ready toggled at random
    do_reset();
    begin
      int lens[6] = '{1, 3, 5, 2, 4, 16};
      int k = 0;
      int idx = 0;
      int g = 0;
      logic fire;
      exp_q.delete();
      foreach (lens[f]) for (int w = 0; w < lens[f]; w++) begin
        exp_q.push_back({(w == lens[f] - 1), 8'(8'h40 + k)});
        k++;
      end
      while (got_q.size() < exp_q.size() && g < 3000) begin
        bus.rd_ready = 1'($urandom_range(0, 1));
        if (idx < exp_q.size()) begin
          bus.wr_valid = 1'b1;
          bus.wr_data  = exp_q[idx][DW-1:0];
          bus.wr_last  = exp_q[idx][DW];
        end else begin
          bus.wr_valid = 1'b0;
        end
        fire = bus.wr_valid && bus.wr_ready;
        tick();
        if (fire) idx++;
        g++;
      end
      bus.wr_valid = 1'b0;
      bus.wr_last  = 1'b0;
      bus.rd_ready = 1'b1;
      tick(); tick(); tick(); tick();
      check("t4_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check("t4_word", 32'(got_q[i]), 32'(exp_q[i]));
    end

    // commit on bank 1 in the same cycle as the release of bank 0
    do_reset();
    bus.rd_ready = 1'b0;
    push_word(8'h71, 1'b1, wa, tr);
    begin
      int g = 0;
      while (!bus.rd_valid && g < 20) begin tick(); g++; end
    end
    push_word(8'h72, 1'b0, wa, tr);
    check("t5_waddr_b1", 32'(wa), 32'h10);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h73;
    bus.wr_last  = 1'b1;
    bus.rd_ready = 1'b1;
    check("t5_pre_last", 32'({bus.rd_valid, bus.rd_last}), 32'd3);
    check("t5_pre_full", 32'(full_cnt), 32'd1);
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    check("t5_post_full", 32'(full_cnt), 32'd1);
    check("t5_wb", 32'(dut.wb_q), 32'd2);
    check("t5_rb", 32'(dut.rb_q), 32'd1);
    wait_out("t5_count", 3);
    check("t5_w2", 32'(got_q[2]), 32'h173);

    // reset mid-frame with two words queued
    do_reset();
    bus.rd_ready = 1'b0;
    push_word(8'h81, 1'b0, wa, tr);
    push_word(8'h82, 1'b1, wa, tr);
    for (int i = 0; i < 6; i++) tick();
    push_word(8'h83, 1'b0, wa, tr);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hEE;
    rst_n = 1'b0;
    tick();
    check("t6_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("t6_rd", 32'({bus.rd_valid, bus.rd_last, bus.rd_data}), 32'd0);
    check("t6_full_cnt", 32'(full_cnt), 32'd0);
    check("t6_en", 32'({ram_read_en, ram_write_en, wr_trunc}), 32'd0);
    bus.wr_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    got_q.delete();
    bus.rd_ready = 1'b1;
    push_word(8'h91, 1'b0, wa, tr);
    check("t6_waddr", 32'(wa), 32'h00);
    push_word(8'h92, 1'b1, wa, tr);
    wait_out("t6_count", 2);
    check("t6_w0", 32'(got_q[0]), 32'h091);
    check("t6_w1", 32'(got_q[1]), 32'h192);
    for (int i = 0; i < 8; i++) tick();
    check("t6_no_stale", 32'(got_q.size()), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
